// File: rtl/tc_mma_arbiter.sv
// -----------------------------------------------------------------------------
// tc_mma_arbiter
// Shares a single tensor_core_int8 MMA unit among NUM_REQ requesters.
// Round-robin grant, issue handshake, wait for result, one-cycle completion
// pulse to the owner. A watchdog aborts an operation that sits in ISSUE+WAIT
// for TIMEOUT_CYC cycles and reports it through rsp_err / err_timeout.
//
// Optional build macro: TC_ARB_PRIORITY_EN
//   defined   - requester 0 wins whenever it requests; requesters 1..N-1
//               share the remaining grants round-robin, and rr_last only
//               tracks non-zero grants.
//   undefined - plain round-robin across all requesters.
// -----------------------------------------------------------------------------
module tc_mma_arbiter #(
   parameter int NUM_REQ     = 4,
   parameter int ID_W        = 2,
   parameter int TIMEOUT_CYC = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_REQ-1:0] req_valid,
   output logic [NUM_REQ-1:0] rsp_valid,
   output logic               rsp_err,
   output logic [ID_W-1:0]    owner_sel,
   output logic               busy,
   output logic               tc_mma_enable,
   output logic               tc_mma_valid,
   input  logic               tc_mma_ready,
   input  logic               tc_result_valid,
   output logic               err_timeout
);

   // FSM encoding
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;
   localparam logic [1:0] S_RESP  = 2'd3;

   // Timer must hold TIMEOUT_CYC-1; one spare bit keeps the width safe for 1.
   localparam int                TMR_W    = $clog2(TIMEOUT_CYC) + 1;
   localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);
   localparam logic [ID_W-1:0]   RR_RESET = ID_W'(NUM_REQ - 1);

   // ---------------------------------------------------------------------
   // State registers
   // ---------------------------------------------------------------------
   logic [1:0]         r_state;
   logic [ID_W-1:0]    r_owner;
   logic [ID_W-1:0]    r_rr_last;
   logic [TMR_W-1:0]   r_timer;
   logic               r_busy;
   logic               r_mma_valid;
   logic [NUM_REQ-1:0] r_rsp_valid;
   logic               r_rsp_err;
   logic               r_err_timeout;

   // Next-state values
   logic [1:0]         w_state_next;
   logic [ID_W-1:0]    w_owner_next;
   logic [ID_W-1:0]    w_rr_last_next;
   logic [TMR_W-1:0]   w_timer_next;
   logic               w_busy_next;
   logic               w_mma_valid_next;
   logic [NUM_REQ-1:0] w_rsp_valid_next;
   logic               w_rsp_err_next;
   logic               w_err_timeout_next;

   // ---------------------------------------------------------------------
   // Arbitration helpers
   // ---------------------------------------------------------------------
   logic [NUM_REQ-1:0] w_req_rr;      // requesters taking part in round-robin
   logic [NUM_REQ-1:0] w_above_last;  // bit i set when i is after rr_last
   logic [NUM_REQ-1:0] w_req_hi;      // round-robin candidates after rr_last
   logic [NUM_REQ-1:0] w_owner_onehot;
   logic [ID_W-1:0]    w_rr_winner;
   logic [ID_W-1:0]    w_winner;
   logic               w_any_req;
   logic               w_timer_expired;

   // Lowest set bit of a request vector (0 when empty; callers gate on that).
   function automatic logic [ID_W-1:0] f_lowest(input logic [NUM_REQ-1:0] vec);
      logic [ID_W-1:0] res;
      res = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (vec[i]) begin
            res = ID_W'(i);
         end
      end
      return res;
   endfunction

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
`ifdef TC_ARB_PRIORITY_EN
         // Requester 0 is handled by the priority override, never by the rotation.
         if (gi == 0) begin : g_rr0
            assign w_req_rr[gi] = 1'b0;
         end else begin : g_rrn
            assign w_req_rr[gi] = req_valid[gi];
         end
`else
         assign w_req_rr[gi] = req_valid[gi];
`endif
         assign w_above_last[gi]   = (r_rr_last < ID_W'(gi));
         assign w_owner_onehot[gi] = (r_owner == ID_W'(gi));
      end
   endgenerate

   assign w_req_hi  = w_req_rr & w_above_last;
   assign w_any_req = |req_valid;

   // First requester after rr_last; wrap to the lowest index when none is above.
   assign w_rr_winner = (|w_req_hi) ? f_lowest(w_req_hi) : f_lowest(w_req_rr);

`ifdef TC_ARB_PRIORITY_EN
   assign w_winner = req_valid[0] ? '0 : w_rr_winner;
`else
   assign w_winner = w_rr_winner;
`endif

   assign w_timer_expired = (r_timer == TMR_LAST);

   // ---------------------------------------------------------------------
   // Next-state logic for the operation sequencer
   // ---------------------------------------------------------------------
   always_comb begin
      w_state_next       = r_state;
      w_owner_next       = r_owner;
      w_rr_last_next     = r_rr_last;
      w_timer_next       = r_timer;
      w_busy_next        = r_busy;
      w_mma_valid_next   = r_mma_valid;
      w_rsp_valid_next   = r_rsp_valid;
      w_rsp_err_next     = r_rsp_err;
      w_err_timeout_next = r_err_timeout;

      case (r_state)
         S_IDLE: begin
            if (w_any_req) begin
               w_state_next     = S_ISSUE;
               w_owner_next     = w_winner;
               w_busy_next      = 1'b1;
               w_mma_valid_next = 1'b1;
               w_timer_next     = '0;
            end
         end

         S_ISSUE: begin
            if (tc_mma_ready) begin
               // Core latched the operands; hold the mux and wait for D.
               w_state_next     = S_WAIT;
               w_mma_valid_next = 1'b0;
               w_timer_next     = r_timer + TMR_W'(1);
            end else if (w_timer_expired) begin
               w_state_next       = S_RESP;
               w_mma_valid_next   = 1'b0;
               w_rsp_valid_next   = w_owner_onehot;
               w_rsp_err_next     = 1'b1;
               w_err_timeout_next = 1'b1;
            end else begin
               w_timer_next = r_timer + TMR_W'(1);
            end
         end

         S_WAIT: begin
            if (tc_result_valid) begin
               w_state_next     = S_RESP;
               w_rsp_valid_next = w_owner_onehot;
               w_rsp_err_next   = 1'b0;
            end else if (w_timer_expired) begin
               w_state_next       = S_RESP;
               w_rsp_valid_next   = w_owner_onehot;
               w_rsp_err_next     = 1'b1;
               w_err_timeout_next = 1'b1;
            end else begin
               w_timer_next = r_timer + TMR_W'(1);
            end
         end

         S_RESP: begin
            // req_valid is ignored here so the finishing owner cannot be re-granted
            // off its own stale request.
            w_state_next     = S_IDLE;
            w_rsp_valid_next = '0;
            w_rsp_err_next   = 1'b0;
            w_busy_next      = 1'b0;
`ifdef TC_ARB_PRIORITY_EN
            if (r_owner != '0) begin
               w_rr_last_next = r_owner;
            end
`else
            w_rr_last_next = r_owner;
`endif
         end

         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------
   // Register update with asynchronous active-low reset
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= S_IDLE;
         r_owner       <= '0;
         r_rr_last     <= RR_RESET;
         r_timer       <= '0;
         r_busy        <= 1'b0;
         r_mma_valid   <= 1'b0;
         r_rsp_valid   <= '0;
         r_rsp_err     <= 1'b0;
         r_err_timeout <= 1'b0;
      end else begin
         r_state       <= w_state_next;
         r_owner       <= w_owner_next;
         r_rr_last     <= w_rr_last_next;
         r_timer       <= w_timer_next;
         r_busy        <= w_busy_next;
         r_mma_valid   <= w_mma_valid_next;
         r_rsp_valid   <= w_rsp_valid_next;
         r_rsp_err     <= w_rsp_err_next;
         r_err_timeout <= w_err_timeout_next;
      end
   end

   // All outputs come straight from registers.
   assign rsp_valid     = r_rsp_valid;
   assign rsp_err       = r_rsp_err;
   assign owner_sel     = r_owner;
   assign busy          = r_busy;
   assign tc_mma_valid  = r_mma_valid;
   assign tc_mma_enable = r_mma_valid;
   assign err_timeout   = r_err_timeout;

endmodule

// File: tb/tb_tc_mma_arbiter.sv
// -----------------------------------------------------------------------------
// tb_tc_mma_arbiter
// Self-checking bench for tc_mma_arbiter. A small core emulator answers the
// issue handshake after a configurable delay and raises result_valid after a
// second delay (or never). Expected grants, latencies and error flags come
// from a transaction-level model: round-robin pick over the pending mask and
// latency = ready delay + result delay + 2, capped at TIMEOUT_CYC.
// Honours TC_ARB_PRIORITY_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_tc_mma_arbiter;

   localparam int NUM_REQ = 4;
   localparam int ID_W    = 2;
   localparam int TO_CYC  = 16;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic [NUM_REQ-1:0] req_valid = '0;
   logic [NUM_REQ-1:0] rsp_valid;
   logic               rsp_err;
   logic [ID_W-1:0]    owner_sel;
   logic               busy;
   logic               tc_mma_enable;
   logic               tc_mma_valid;
   logic               tc_mma_ready = 1'b0;
   logic               tc_result_valid = 1'b0;
   logic               err_timeout;

   tc_mma_arbiter #(
      .NUM_REQ    (NUM_REQ),
      .ID_W       (ID_W),
      .TIMEOUT_CYC(TO_CYC)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .req_valid      (req_valid),
      .rsp_valid      (rsp_valid),
      .rsp_err        (rsp_err),
      .owner_sel      (owner_sel),
      .busy           (busy),
      .tc_mma_enable  (tc_mma_enable),
      .tc_mma_valid   (tc_mma_valid),
      .tc_mma_ready   (tc_mma_ready),
      .tc_result_valid(tc_result_valid),
      .err_timeout    (err_timeout)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   // Core emulator configuration: cycles before ready, cycles before result (-1 = never)
   int cfg_rdy = 0;
   int cfg_res = 0;
   int iss_cnt = 0;
   int wt_cnt  = 0;

   // Reference model state
   logic [NUM_REQ-1:0] pending  = '0;
   int                 model_rr = NUM_REQ - 1;
   bit                 model_err = 1'b0;
   int                 drop_mode = 0;  // 0 owner drops, 1 all held, 2 owner drops + random arrivals
   int                 grant_log[$];

   // Core emulator: drives ready/result from what the arbiter is showing this cycle.
   always @(negedge clk) begin
      if (!rst_n) begin
         tc_mma_ready    = 1'b0;
         tc_result_valid = 1'b0;
         iss_cnt         = 0;
         wt_cnt          = 0;
      end else begin
         if (tc_mma_valid) begin
            tc_mma_ready = (iss_cnt >= cfg_rdy);
            iss_cnt++;
         end else begin
            tc_mma_ready = 1'b0;
            iss_cnt      = 0;
         end
         if (busy && !tc_mma_valid && rsp_valid == '0) begin
            tc_result_valid = (cfg_res >= 0) && (wt_cnt >= cfg_res);
            wt_cnt++;
         end else begin
            tc_result_valid = 1'b0;
            wt_cnt          = 0;
         end
      end
   end

   // Round-robin pick straight from the arbitration rule.
   function automatic int model_pick(input logic [NUM_REQ-1:0] m, input int rr);
      int idx;
`ifdef TC_ARB_PRIORITY_EN
      if (m[0]) return 0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = (rr + k) % NUM_REQ;
         if (idx != 0 && m[idx]) return idx;
      end
`else
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = (rr + k) % NUM_REQ;
         if (m[idx]) return idx;
      end
`endif
      return -1;
   endfunction

   // One full operation. Entered at a negedge with the arbiter idle and
   // req_valid already driven; leaves at the negedge of the following IDLE cycle.
   task automatic do_op(input int rdy, input int res, input string tag);
      int exp_w, exp_c, exp_vc, c, vc;
      bit exp_e, seen, stable_bad, en_bad;
      logic [NUM_REQ-1:0] exp_oh;
      exp_w   = model_pick(pending, model_rr);
      cfg_rdy = rdy;
      cfg_res = res;
      exp_e   = (res < 0) || (rdy + res + 2 > TO_CYC);
      exp_c   = exp_e ? TO_CYC : rdy + res + 2;
      exp_vc  = (rdy + 1 < TO_CYC) ? rdy + 1 : TO_CYC;
      exp_oh  = '0;
      if (exp_w >= 0) exp_oh[exp_w] = 1'b1;

      @(negedge clk);
      n_checks++;
      if (busy !== 1'b1 || int'(owner_sel) != exp_w) begin
         $display("FAIL %s_grant: busy=%b owner_sel=%0d, required busy=1 owner_sel=%0d",
                  tag, busy, owner_sel, exp_w);
         return;
      end else n_pass++;
      grant_log.push_back(int'(owner_sel));

      c = 0; vc = 0; seen = 0; stable_bad = 0; en_bad = 0;
      while (c < 60) begin
         if (rsp_valid != '0) begin
            seen = 1;
            break;
         end
         if (tc_mma_valid) vc++;
         if (int'(owner_sel) != exp_w || busy !== 1'b1) stable_bad = 1;
         if (tc_mma_enable !== tc_mma_valid) en_bad = 1;
         @(negedge clk);
         c++;
      end

      n_checks++;
      if (!seen) begin
         $display("FAIL %s_rsp_timeout: no rsp_valid within 60 cycles, required one at cycle %0d",
                  tag, exp_c);
         return;
      end else n_pass++;

      n_checks++;
      if (c != exp_c) $display("FAIL %s_latency: rsp at cycle %0d, required %0d", tag, c, exp_c);
      else n_pass++;

      n_checks++;
      if (vc != exp_vc) $display("FAIL %s_valid_len: tc_mma_valid high %0d cycles, required %0d", tag, vc, exp_vc);
      else n_pass++;

      n_checks++;
      if (rsp_valid !== exp_oh || rsp_err !== exp_e || owner_sel !== exp_oh[0] * 0 + ID_W'(exp_w))
         $display("FAIL %s_rsp: rsp_valid=%b rsp_err=%b owner_sel=%0d, required %b %b %0d",
                  tag, rsp_valid, rsp_err, owner_sel, exp_oh, exp_e, exp_w);
      else n_pass++;

      n_checks++;
      if (stable_bad || en_bad)
         $display("FAIL %s_stable: owner/busy changed=%b enable!=valid=%b, required 0 0", tag, stable_bad, en_bad);
      else n_pass++;

      model_err = model_err | exp_e;
      n_checks++;
      if (err_timeout !== model_err)
         $display("FAIL %s_err_timeout: err_timeout=%b, required %b", tag, err_timeout, model_err);
      else n_pass++;

`ifdef TC_ARB_PRIORITY_EN
      if (exp_w != 0) model_rr = exp_w;
`else
      model_rr = exp_w;
`endif
      $display("op %s: owner=%0d rdy=%0d res=%0d latency=%0d err=%0b", tag, exp_w, rdy, res, c, exp_e);

      // Requester reaction during its rsp_valid cycle
      if (drop_mode != 1) pending[exp_w] = 1'b0;
      req_valid = pending;

      @(negedge clk);
      n_checks++;
      if (busy !== 1'b0 || rsp_valid !== '0 || tc_mma_valid !== 1'b0)
         $display("FAIL %s_idle: busy=%b rsp_valid=%b tc_mma_valid=%b, required 0 0 0",
                  tag, busy, rsp_valid, tc_mma_valid);
      else n_pass++;

      if (drop_mode == 2) begin
         pending = pending | NUM_REQ'($urandom);
         if (pending == '0) pending[$urandom_range(0, NUM_REQ - 1)] = 1'b1;
         req_valid = pending;
      end
   endtask

   // Leave the arbiter idle with nothing requesting (called at an IDLE negedge).
   task automatic quiesce();
      pending   = '0;
      req_valid = '0;
   endtask

   task automatic single(input logic [NUM_REQ-1:0] mask, input int rdy, input int res, input string tag);
      drop_mode = 0;
      pending   = mask;
      req_valid = mask;
      do_op(rdy, res, tag);
      quiesce();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_checks++;
      if ({rsp_valid, rsp_err, owner_sel, busy, tc_mma_valid, tc_mma_enable, err_timeout} !== '0)
         $display("FAIL reset_values: rsp_valid=%b rsp_err=%b owner=%0d busy=%b valid=%b en=%b err=%b, required all 0",
                  rsp_valid, rsp_err, owner_sel, busy, tc_mma_valid, tc_mma_enable, err_timeout);
      else n_pass++;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b0 || tc_mma_valid !== 1'b0)
         $display("FAIL reset_idle: busy=%b valid=%b, required 0 0", busy, tc_mma_valid);
      else n_pass++;
      model_rr  = NUM_REQ - 1;
      model_err = 1'b0;
   endtask

   task automatic test_all_four();
      int exp_order[4] = '{0, 1, 2, 3};
      grant_log.delete();
      drop_mode = 0;
      pending   = '1;
      req_valid = pending;
      for (int i = 0; i < NUM_REQ; i++) do_op($urandom_range(0, 2), $urandom_range(0, 3), "all_four");
      quiesce();
      n_checks++;
      if (grant_log.size() != 4 || grant_log[0] != exp_order[0] || grant_log[1] != exp_order[1] ||
          grant_log[2] != exp_order[2] || grant_log[3] != exp_order[3])
         $display("FAIL all_four_order: got %p, required 0,1,2,3", grant_log);
      else n_pass++;
   endtask

   task automatic test_min_latency();
      single(4'b0001, 0, 0, "min_latency");
   endtask

   task automatic test_ready_stall();
      single(4'b0100, 5, 0, "ready_stall");
   endtask

   task automatic test_timeout();
      single(4'b1000, 0, -1, "timeout_wait");
      single(4'b0010, 0, 0, "after_timeout");
      single(4'b0001, 3, 11, "edge_in_time");
      single(4'b0100, 3, 12, "edge_late");
      single(4'b0010, 20, 0, "timeout_issue");
      single(4'b1000, 1, 2, "sticky_check");
   endtask

   task automatic test_reset_mid();
      pending   = 4'b0010;
      req_valid = pending;
      cfg_rdy   = 0;
      cfg_res   = -1;
      repeat (3) @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if ({rsp_valid, rsp_err, owner_sel, busy, tc_mma_valid, tc_mma_enable, err_timeout} !== '0)
         $display("FAIL reset_mid_async: rsp_valid=%b rsp_err=%b owner=%0d busy=%b valid=%b en=%b err=%b, required all 0",
                  rsp_valid, rsp_err, owner_sel, busy, tc_mma_valid, tc_mma_enable, err_timeout);
      else n_pass++;
      quiesce();
      repeat (2) begin
         @(negedge clk);
         n_checks++;
         if (rsp_valid !== '0 || busy !== 1'b0)
            $display("FAIL reset_mid_hold: rsp_valid=%b busy=%b, required 0 0", rsp_valid, busy);
         else n_pass++;
      end
      rst_n     = 1'b1;
      model_rr  = NUM_REQ - 1;
      model_err = 1'b0;
      @(negedge clk);
      grant_log.delete();
      single(4'b0100, 0, 0, "after_reset");
      n_checks++;
      if (grant_log.size() != 1 || grant_log[0] != 2)
         $display("FAIL after_reset_owner: got %p, required 2", grant_log);
      else n_pass++;
   endtask

   task automatic test_alternate();
`ifdef TC_ARB_PRIORITY_EN
      int exp_order[4] = '{0, 0, 0, 0};
`else
      int exp_order[4] = '{0, 2, 0, 2};
`endif
      bit bad;
      grant_log.delete();
      drop_mode = 1;
      pending   = 4'b0101;
      req_valid = pending;
      for (int i = 0; i < 4; i++) do_op(0, $urandom_range(0, 2), "alternate");
      quiesce();
      bad = (grant_log.size() != 4);
      for (int i = 0; i < 4 && !bad; i++) if (grant_log[i] != exp_order[i]) bad = 1;
      n_checks++;
      if (bad) $display("FAIL alternate_order: got %p, required %p", grant_log, exp_order);
      else n_pass++;
   endtask

   task automatic test_random();
      drop_mode = 2;
      pending   = NUM_REQ'($urandom);
      if (pending == '0) pending = 4'b1000;
      req_valid = pending;
      for (int i = 0; i < 40; i++) begin
         int res;
         res = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 8));
         do_op($urandom_range(0, 4), res, "random");
      end
      quiesce();
   endtask

   initial begin
      test_reset();
      test_all_four();
      test_min_latency();
      test_ready_stall();
      test_timeout();
      test_reset_mid();
      test_alternate();
      test_random();
      repeat (2) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   // Hard stop so the run always ends.
   initial begin
      #200000;
      $display("FAIL global_timeout: simulation exceeded time limit, required completion");
      $fatal(1, "time limit");
   end

endmodule
